// File: rtl/uart_tx_fifo.sv
// Transmit FIFO that queues bytes and hands them one at a time to a downstream
// uart_tx stage using a start pulse / busy handshake.
module uart_tx_fifo #(
  parameter int DBIT  = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic [DBIT-1:0]          i_wr_data,
  input  logic                     i_flush,
  input  logic                     i_tx_busy,
  output logic                     o_tx_start,
  output logic [DBIT-1:0]          o_tx_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  logic [DBIT-1:0] mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            overflow_r;
  logic            head_vld_r;
  logic [DBIT-1:0] head_r;
  logic [DBIT-1:0] tx_data_r;
  logic            start_r;
  state_t          state_r;
  state_t          state_next_s;
  logic            full_s;
  logic            empty_s;
  logic            wr_acc_s;
  logic            wr_drop_s;
  logic            pop_s;

  assign full_s    = (count_r == DEPTH_C);
  assign empty_s   = (count_r == {CW{1'b0}});
  assign wr_acc_s  = i_wr_en & ~full_s & ~i_flush;
  assign wr_drop_s = i_wr_en &  full_s & ~i_flush;

  // Next-state and pop decision; a pop also requires the registered head copy
  // to be settled, which keeps a freshly written byte from launching early.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s && head_vld_r && !i_tx_busy && !i_flush) begin
          pop_s        = 1'b1;
          state_next_s = LOAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD: begin
        state_next_s = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (i_tx_busy) begin
          state_next_s = WAIT_DONE;
        end else begin
          state_next_s = WAIT_BUSY;
        end
      end
      WAIT_DONE: begin
        if (!i_tx_busy) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT_DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM state register; flush deliberately leaves an in-flight byte running.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Pointers, occupancy, sticky overflow and head-valid tracking.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
      head_vld_r <= 1'b0;
    end else if (i_flush) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
      head_vld_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r    <= count_r + CW'(wr_acc_s) - CW'(pop_s);
      overflow_r <= overflow_r | wr_drop_s;
      head_vld_r <= ~empty_s;
    end
  end

  // Storage array; written only on accepted writes.
  always_ff @(posedge i_clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= i_wr_data;
    end
  end

  // Registered copy of the entry at the read pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_r <= {DBIT{1'b0}};
    end else begin
      head_r <= mem_r[rd_ptr_r];
    end
  end

  // Transmit data holds from one pop to the next; start is high exactly in LOAD.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_data_r <= {DBIT{1'b0}};
      start_r   <= 1'b0;
    end else begin
      if (pop_s) begin
        tx_data_r <= head_r;
      end
      start_r <= (state_next_s == LOAD);
    end
  end

  assign o_tx_start = start_r;
  assign o_tx_data  = tx_data_r;
  assign o_full     = full_s;
  assign o_empty    = empty_s;
  assign o_count    = count_r;
  assign o_overflow = overflow_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus randomized
// traffic scored against a queue-based reference model.
module tb_uart_tx_fifo;

  localparam int DBIT  = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic            i_wr_en;
  logic [DBIT-1:0] i_wr_data;
  logic            i_flush;
  logic            i_tx_busy;
  logic            o_tx_start;
  logic [DBIT-1:0] o_tx_data;
  logic            o_full;
  logic            o_empty;
  logic [CW-1:0]   o_count;
  logic            o_overflow;

  uart_tx_fifo #(.DBIT(DBIT), .DEPTH(DEPTH)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_wr_en    (i_wr_en),
    .i_wr_data  (i_wr_data),
    .i_flush    (i_flush),
    .i_tx_busy  (i_tx_busy),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_starts = 0;
  int busy_cnt = 0;
  bit busy_auto = 1'b0;
  bit prev_start = 1'b0;
  bit m_ovf = 1'b0;
  logic [DBIT-1:0] q[$];
  logic [DBIT-1:0] rx[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // One clock: update the model from the pre-edge inputs, then score outputs.
  task automatic step();
    logic            wr;
    logic            fl;
    logic            rs;
    logic [DBIT-1:0] d;
    logic [DBIT-1:0] exp_b;
    wr = i_wr_en; fl = i_flush; rs = i_rst_n; d = i_wr_data;
    @(posedge i_clk);
    #1;
    if (!rs || fl) begin
      q.delete();
      m_ovf = 1'b0;
    end else if (wr) begin
      if (q.size() < DEPTH) q.push_back(d);
      else m_ovf = 1'b1;
    end
    if (o_tx_start) begin
      n_starts++;
      check_eq("start_one_cycle", 32'(prev_start), 32'd0);
      check_eq("start_has_data", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        exp_b = q.pop_front();
        check_eq("tx_data", 32'(o_tx_data), 32'(exp_b));
        rx.push_back(o_tx_data);
      end
    end
    prev_start = o_tx_start;
    check_eq("count", 32'(o_count), 32'(q.size()));
    check_eq("full", 32'(o_full), 32'(q.size() == DEPTH));
    check_eq("empty", 32'(o_empty), 32'(q.size() == 0));
    check_eq("overflow", 32'(o_overflow), 32'(m_ovf));
    if (busy_auto) begin
      if (busy_cnt > 0) busy_cnt--;
      if (o_tx_start) busy_cnt = 10;
      i_tx_busy = (busy_cnt > 0);
    end
  endtask

  task automatic push_byte(input logic [DBIT-1:0] b);
    i_wr_en = 1'b1;
    i_wr_data = b;
    step();
    i_wr_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    int quiet;
    bit done;
    quiet = 0;
    done = 1'b0;
    i_wr_en = 1'b0;
    i_flush = 1'b0;
    for (int k = 0; k < 1000 && !done; k++) begin
      step();
      if (q.size() == 0 && !o_tx_start) quiet++;
      else quiet = 0;
      if (quiet >= 20) done = 1'b1;
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_start"}, 32'(o_tx_start), 32'd0);
    check_eq({tag, "_data"}, 32'(o_tx_data), 32'd0);
    check_eq({tag, "_count"}, 32'(o_count), 32'd0);
    check_eq({tag, "_empty"}, 32'(o_empty), 32'd1);
    check_eq({tag, "_full"}, 32'(o_full), 32'd0);
    check_eq({tag, "_ovf"}, 32'(o_overflow), 32'd0);
  endtask

  initial begin
    int base;
    int n0;
    int seq;
    bit acc;
    i_rst_n = 1'b1; i_wr_en = 1'b0; i_wr_data = '0; i_flush = 1'b0; i_tx_busy = 1'b0;
    #1 i_rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    step(); step();
    i_rst_n = 1'b1;
    busy_auto = 1'b1;

    // Single byte: start rises exactly at the second edge after the write.
    push_byte(8'hA5);
    check_eq("single_e0_start", 32'(o_tx_start), 32'd0);
    step();
    check_eq("single_e1_start", 32'(o_tx_start), 32'd0);
    step();
    check_eq("single_e2_start", 32'(o_tx_start), 32'd1);
    check_eq("single_e2_data", 32'(o_tx_data), 32'hA5);
    check_eq("single_e2_count", 32'(o_count), 32'd0);
    step();
    check_eq("single_e3_start", 32'(o_tx_start), 32'd0);
    drain("single_drain");

    // Fill past full with the transmitter held busy.
    busy_auto = 1'b0; i_tx_busy = 1'b1;
    for (int i = 0; i <= 16; i++) push_byte(DBIT'(i));
    check_eq("fill_full", 32'(o_full), 32'd1);
    check_eq("fill_count", 32'(o_count), 32'd16);
    check_eq("fill_ovf", 32'(o_overflow), 32'd1);
    base = rx.size();
    busy_auto = 1'b1; busy_cnt = 0; i_tx_busy = 1'b0;
    drain("fill_drain");
    check_eq("fill_nbytes", 32'(rx.size() - base), 32'd16);
    check_eq("fill_last", 32'(rx[rx.size()-1]), 32'h0F);
    i_flush = 1'b1; step(); i_flush = 1'b0;
    check_eq("fill_ovf_cleared", 32'(o_overflow), 32'd0);

    // Write on the same edge as a pop with three entries held.
    busy_auto = 1'b0; i_tx_busy = 1'b1;
    for (int i = 0; i < 3; i++) push_byte(DBIT'(8'h20 + i));
    i_wr_en = 1'b1; i_wr_data = 8'h23;
    i_tx_busy = 1'b0; busy_auto = 1'b1; busy_cnt = 0;
    step();
    i_wr_en = 1'b0;
    check_eq("simul_start", 32'(o_tx_start), 32'd1);
    check_eq("simul_count", 32'(o_count), 32'd3);
    drain("simul_drain");

    // Ordered stream of 40 bytes with random write gaps, wrapping the buffer.
    base = rx.size();
    seq = 0;
    for (int k = 0; k < 4000 && seq < 40; k++) begin
      i_wr_en = ($urandom_range(0, 3) != 0);
      i_wr_data = DBIT'(seq);
      acc = i_wr_en && (q.size() < DEPTH);
      step();
      if (acc) seq++;
    end
    i_wr_en = 1'b0;
    drain("stream_drain");
    check_eq("stream_nbytes", 32'(rx.size() - base), 32'd40);
    for (int k = 0; k < 40 && base + k < rx.size(); k++)
      check_eq("stream_order", 32'(rx[base+k]), 32'(k));

    // Flush while the current byte is in WAIT_DONE with five entries queued.
    busy_auto = 1'b0; i_tx_busy = 1'b1;
    for (int i = 0; i < 6; i++) push_byte(DBIT'(8'h50 + i));
    i_tx_busy = 1'b0;
    step();
    check_eq("flush_pop_start", 32'(o_tx_start), 32'd1);
    i_tx_busy = 1'b1;
    step(); step();
    check_eq("flush_pre_count", 32'(o_count), 32'd5);
    i_flush = 1'b1; i_wr_en = 1'b1; i_wr_data = 8'hEE;
    step();
    i_flush = 1'b0; i_wr_en = 1'b0;
    check_eq("flush_count", 32'(o_count), 32'd0);
    check_eq("flush_ovf", 32'(o_overflow), 32'd0);
    check_eq("flush_empty", 32'(o_empty), 32'd1);
    check_eq("flush_inflight_data", 32'(o_tx_data), 32'h50);
    step(); step(); step();
    i_tx_busy = 1'b0;
    n0 = n_starts;
    busy_auto = 1'b1; busy_cnt = 0;
    for (int k = 0; k < 30; k++) step();
    check_eq("flush_no_more_starts", 32'(n_starts), 32'(n0));

    // Asynchronous reset while waiting for busy with four entries queued.
    busy_auto = 1'b0; i_tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(DBIT'(8'h70 + i));
    i_tx_busy = 1'b0;
    step();
    check_eq("rst_pop_start", 32'(o_tx_start), 32'd1);
    step();
    check_eq("rst_pre_count", 32'(o_count), 32'd4);
    #2 i_rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    q.delete(); m_ovf = 1'b0;
    step(); step();
    i_rst_n = 1'b1;
    busy_auto = 1'b1; busy_cnt = 0; i_tx_busy = 1'b0;
    n0 = n_starts;
    for (int k = 0; k < 20; k++) step();
    check_eq("rst_no_start", 32'(n_starts), 32'(n0));
    push_byte(8'h3C);
    drain("rst_drain");
    check_eq("rst_new_start", 32'(n_starts), 32'(n0 + 1));
    check_eq("rst_new_data", 32'(o_tx_data), 32'h3C);

    // Random traffic with occasional flushes and overflow.
    for (int k = 0; k < 600; k++) begin
      i_wr_en = $urandom_range(0, 1) != 0;
      i_wr_data = DBIT'($urandom);
      i_flush = ($urandom_range(0, 63) == 0);
      step();
    end
    i_flush = 1'b0;
    drain("random_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DBIT, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries; power of 2, >= 2.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_wr_en  input  1  write request for i_wr_data.
REQ-006 SHALL have port i_wr_data  input  DBIT  byte to queue.
REQ-007 SHALL have port i_flush  input  1  synchronous clear of queued entries and overflow flag.
REQ-008 SHALL have port i_tx_busy  input  1  busy from the downstream uart_tx stage.
REQ-009 SHALL have port o_tx_start  output  1  one-cycle start pulse to the transmitter.
REQ-010 SHALL have port o_tx_data  output  DBIT  registered byte for the transmitter.
REQ-011 SHALL have port o_full  output  1  count == DEPTH.
REQ-012 SHALL have port o_empty  output  1  count == 0.
REQ-013 SHALL have port o_count  output  $clog2(DEPTH)+1  entries held, 0..DEPTH.
REQ-014 SHALL have port o_overflow  output  1  sticky; write attempted while full.

Function
REQ-015 SHALL store entries in a circular buffer with write and read pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-016 SHALL accept a write when i_wr_en=1, o_full=0 and i_flush=0, storing i_wr_data at the write pointer and advancing it.
REQ-017 SHALL drop a write when i_wr_en=1, o_full=1 and i_flush=0, leave contents unchanged and set o_overflow to 1.
REQ-018 SHALL derive o_full, o_empty and o_count from registered state only, with no combinational path from inputs.
REQ-019 SHALL implement FSM states IDLE, LOAD, WAIT_BUSY and WAIT_DONE.
REQ-020 SHALL pop in IDLE when o_empty=0, i_tx_busy=0 and i_flush=0: load the head entry into o_tx_data, advance the read pointer, go to LOAD.
REQ-021 SHALL drive o_tx_start=1 only in LOAD (Moore), then go to WAIT_BUSY unconditionally.
REQ-022 SHALL stay in WAIT_BUSY until i_tx_busy=1, then go to WAIT_DONE.
REQ-023 SHALL stay in WAIT_DONE until i_tx_busy=0, then go to IDLE.
REQ-024 SHALL hold o_tx_data stable from the pop edge until the next pop.
REQ-025 SHALL, on a same-edge accepted write and pop, leave o_count unchanged and update both pointers.
REQ-026 SHALL not pass data through in the write cycle: the earliest o_tx_start is the second rising edge after the accepting edge.
REQ-027 SHALL, on i_flush=1, reset both pointers, o_count and o_overflow to 0 and ignore i_wr_en; flush takes priority over write and pop on that edge.
REQ-028 SHALL let i_flush leave the FSM state and o_tx_data unchanged, so an in-flight byte completes.
REQ-029 SHALL permit a write in the same cycle o_full deasserts (registered view), never exceeding DEPTH entries.

Reset
REQ-030 SHALL, on i_rst_n=0, immediately set FSM=IDLE, pointers=0, o_count=0, o_empty=1, o_full=0, o_overflow=0, o_tx_start=0, o_tx_data=0, independent of i_clk.
REQ-031 SHALL discard all queued and in-flight data on reset mid-operation and resume in IDLE after deassertion.
REQ-032 SHALL accept no write or pop on the first rising edge at which i_rst_n is sampled low.

Verification
REQ-033 SHALL verify single byte: write 0xA5 at edge 0 with i_tx_busy=0 -> o_tx_start high for one cycle after edge 2, o_tx_data=0xA5, o_count back to 0.
REQ-034 SHALL verify fill/overflow: DEPTH=16, i_tx_busy held 1, write 17 bytes 0x00..0x10 -> o_full=1, o_count=16, o_overflow=1, 0x10 absent from output order.
REQ-035 SHALL verify ordering and wrap-around: stream 40 bytes with busy modelled as 1 for 10 cycles per start -> bytes emerge in write order 0..39 with no loss.
REQ-036 SHALL verify simultaneous write and pop: count=3, write at the pop edge -> o_count stays 3.
REQ-037 SHALL verify flush: count=5, in WAIT_DONE, i_flush with i_wr_en -> count=0, overflow=0, write dropped, current byte completes, no further start.
REQ-038 SHALL verify reset mid-operation: assert i_rst_n=0 in WAIT_BUSY with count=4 -> all outputs take reset values without a clock edge; no o_tx_start after release until a new write.
